// File: rtl/stochastic_epoch_controller.sv
// ============================================================================
// Module   : stochastic_epoch_controller
// Purpose  : Sequences one stochastic bitstream epoch (warm-up + 2^L counted
//            cycles) per operand pair and returns three scaled ones-counts.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stochastic_epoch_controller #(
    parameter int OPW    = 9,
    parameter int WARMUP = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [4:0]     cfg_log2_len,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [OPW-1:0] op_a,
    input  logic [OPW-1:0] op_b,
    output logic [OPW-1:0] op_a_q,
    output logic [OPW-1:0] op_b_q,
    output logic           lfsr_load,
    output logic           sn_en,
    input  logic           sn_mul,
    input  logic           sn_add,
    input  logic           sn_smul,
    input  logic           abort,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [OPW-1:0] res_mul,
    output logic [OPW-1:0] res_add,
    output logic [OPW-1:0] res_smul,
    output logic           busy
);

    localparam int                 c_cnt_w    = 18;
    localparam logic [4:0]         c_min_log2 = 5'd9;
    localparam logic [4:0]         c_max_log2 = 5'd17;
    localparam logic [c_cnt_w-1:0] c_sat      = c_cnt_w'((1 << OPW) - 1);
    localparam logic [c_cnt_w-1:0] c_warm_end = c_cnt_w'(WARMUP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [4:0]         r_len;
    logic [c_cnt_w-1:0] r_cyc;
    logic [c_cnt_w-1:0] r_cnt_mul;
    logic [c_cnt_w-1:0] r_cnt_add;
    logic [c_cnt_w-1:0] r_cnt_smul;

    logic [4:0]         w_len_clamped;
    logic [c_cnt_w-1:0] w_run_last_cyc;
    logic [c_cnt_w-1:0] w_mul_next;
    logic [c_cnt_w-1:0] w_add_next;
    logic [c_cnt_w-1:0] w_smul_next;

    // Scale a ones-count from 2^L samples down to the 2^9 result range.
    function automatic logic [OPW-1:0] scale(input logic [c_cnt_w-1:0] cnt,
                                             input logic [4:0]         len);
        logic [c_cnt_w-1:0] shifted;
        shifted = cnt >> (len - c_min_log2);
        if (shifted > c_sat) begin
            return '1;
        end
        return shifted[OPW-1:0];
    endfunction

    assign w_len_clamped  = (cfg_log2_len < c_min_log2) ? c_min_log2 :
                            (cfg_log2_len > c_max_log2) ? c_max_log2 : cfg_log2_len;
    assign w_run_last_cyc = (c_cnt_w'(1) << r_len) - c_cnt_w'(1);
    assign w_mul_next     = r_cnt_mul  + {{(c_cnt_w-1){1'b0}}, sn_mul};
    assign w_add_next     = r_cnt_add  + {{(c_cnt_w-1){1'b0}}, sn_add};
    assign w_smul_next    = r_cnt_smul + {{(c_cnt_w-1){1'b0}}, sn_smul};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= c_min_log2;
            r_cyc      <= '0;
            r_cnt_mul  <= '0;
            r_cnt_add  <= '0;
            r_cnt_smul <= '0;
            op_ready   <= 1'b1;
            op_a_q     <= '0;
            op_b_q     <= '0;
            lfsr_load  <= 1'b0;
            sn_en      <= 1'b0;
            res_valid  <= 1'b0;
            res_mul    <= '0;
            res_add    <= '0;
            res_smul   <= '0;
            busy       <= 1'b0;
        end else begin
            lfsr_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_a_q     <= op_a;
                        op_b_q     <= op_b;
                        r_len      <= w_len_clamped;
                        r_cyc      <= '0;
                        r_cnt_mul  <= '0;
                        r_cnt_add  <= '0;
                        r_cnt_smul <= '0;
                        r_state    <= S_WARM;
                        op_ready   <= 1'b0;
                        busy       <= 1'b1;
                        sn_en      <= 1'b1;
                        lfsr_load  <= 1'b1;
                    end
                end
                S_WARM: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        op_ready <= 1'b1;
                        busy     <= 1'b0;
                        sn_en    <= 1'b0;
                    end else if (r_cyc == c_warm_end) begin
                        r_cyc   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_cyc <= r_cyc + c_cnt_w'(1);
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        op_ready <= 1'b1;
                        busy     <= 1'b0;
                        sn_en    <= 1'b0;
                    end else begin
                        r_cnt_mul  <= w_mul_next;
                        r_cnt_add  <= w_add_next;
                        r_cnt_smul <= w_smul_next;
                        // Results include the final sample taken on this edge.
                        if (r_cyc == w_run_last_cyc) begin
                            r_state   <= S_DONE;
                            sn_en     <= 1'b0;
                            res_valid <= 1'b1;
                            res_mul   <= scale(w_mul_next, r_len);
                            res_add   <= scale(w_add_next, r_len);
                            res_smul  <= scale(w_smul_next, r_len);
                        end else begin
                            r_cyc <= r_cyc + c_cnt_w'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state   <= S_IDLE;
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stochastic_epoch_controller.sv
// ============================================================================
// Module   : tb_stochastic_epoch_controller
// Purpose  : Directed self-checking bench for stochastic_epoch_controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stochastic_epoch_controller;

    localparam int OPW    = 9;
    localparam int WARMUP = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4:0]     cfg_log2_len = 5'd9;
    logic           op_valid = 1'b0;
    logic           op_ready;
    logic [OPW-1:0] op_a = '0;
    logic [OPW-1:0] op_b = '0;
    logic [OPW-1:0] op_a_q;
    logic [OPW-1:0] op_b_q;
    logic           lfsr_load;
    logic           sn_en;
    logic           sn_mul;
    logic           sn_add;
    logic           sn_smul;
    logic           abort = 1'b0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [OPW-1:0] res_mul;
    logic [OPW-1:0] res_add;
    logic [OPW-1:0] res_smul;
    logic           busy;

    int total = 0;
    int bad   = 0;

    // Bit pattern per channel: 0 tied low, 1 tied high, 2 alternating, 3 one-in-four.
    int         mode_mul  = 0;
    int         mode_add  = 0;
    int         mode_smul = 0;
    logic [1:0] ph = 2'd0;

    function automatic logic sn_bit(input int mode, input logic [1:0] p);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return p[0];
            default: return (p == 2'd0);
        endcase
    endfunction

    assign sn_mul  = sn_bit(mode_mul, ph);
    assign sn_add  = sn_bit(mode_add, ph);
    assign sn_smul = sn_bit(mode_smul, ph);

    always #5 clk = ~clk;
    always @(negedge clk) ph <= ph + 2'd1;

    stochastic_epoch_controller #(.OPW(OPW), .WARMUP(WARMUP)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_log2_len(cfg_log2_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_a_q(op_a_q), .op_b_q(op_b_q), .lfsr_load(lfsr_load), .sn_en(sn_en),
        .sn_mul(sn_mul), .sn_add(sn_add), .sn_smul(sn_smul), .abort(abort),
        .res_valid(res_valid), .res_ready(res_ready), .res_mul(res_mul),
        .res_add(res_add), .res_smul(res_smul), .busy(busy)
    );

    // Offers one operand pair, then counts cycles until res_valid or limit.
    // The cfg input is scrambled right after acceptance; it must not matter.
    task automatic run_epoch(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                             input logic [4:0] cfg, input int limit,
                             output int lat, output int load_cnt,
                             output int load_idx, output int en_cnt);
        op_a = a; op_b = b; cfg_log2_len = cfg; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        cfg_log2_len = 5'd31;
        lat = 0; load_cnt = 0; load_idx = -1; en_cnt = 0;
        while (!res_valid && lat < limit) begin
            if (lfsr_load) begin
                load_cnt++;
                if (load_idx < 0) load_idx = lat;
            end
            if (sn_en) en_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL rst_op_ready got=%b want=1", op_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (sn_en !== 1'b0 || lfsr_load !== 1'b0) begin bad++; $display("FAIL rst_sn got=%b%b want=00", sn_en, lfsr_load); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", res_valid); end
        total++; if ({res_mul, res_add, res_smul} !== '0) begin bad++; $display("FAIL rst_results got=%0d/%0d/%0d want=0/0/0", res_mul, res_add, res_smul); end
        total++; if ({op_a_q, op_b_q} !== '0) begin bad++; $display("FAIL rst_opq got=%h/%h want=0/0", op_a_q, op_b_q); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_l9_basic();
        int lat, lc, li, ec;
        mode_mul = 1; mode_add = 0; mode_smul = 2;
        run_epoch(9'h0A5, 9'h13C, 5'd9, 600, lat, lc, li, ec);
        total++; if (lat != 514) begin bad++; $display("FAIL l9_latency got=%0d want=514", lat); end
        total++; if (res_mul !== 9'd511) begin bad++; $display("FAIL l9_res_mul got=%0d want=511", res_mul); end
        total++; if (res_add !== 9'd0) begin bad++; $display("FAIL l9_res_add got=%0d want=0", res_add); end
        total++; if (res_smul !== 9'd256) begin bad++; $display("FAIL l9_res_smul got=%0d want=256", res_smul); end
        total++; if (op_a_q !== 9'h0A5 || op_b_q !== 9'h13C) begin bad++; $display("FAIL l9_opq got=%h/%h want=0a5/13c", op_a_q, op_b_q); end
        total++; if (ec != 514) begin bad++; $display("FAIL l9_sn_en_cycles got=%0d want=514", ec); end
        total++; if (op_ready !== 1'b0 || busy !== 1'b1 || sn_en !== 1'b0) begin bad++; $display("FAIL l9_done_flags got=%b%b%b want=010", op_ready, busy, sn_en); end
        consume();
        total++; if (res_valid !== 1'b0 || op_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL l9_after_hs got=%b%b%b want=010", res_valid, op_ready, busy); end
    endtask

    task automatic test_l10();
        int lat, lc, li, ec;
        mode_mul = 2; mode_add = 1; mode_smul = 0;
        run_epoch(9'h011, 9'h022, 5'd10, 1100, lat, lc, li, ec);
        total++; if (lat != 1026) begin bad++; $display("FAIL l10_latency got=%0d want=1026", lat); end
        total++; if (res_mul !== 9'd256) begin bad++; $display("FAIL l10_res_mul got=%0d want=256", res_mul); end
        total++; if (res_add !== 9'd511) begin bad++; $display("FAIL l10_res_add got=%0d want=511", res_add); end
        total++; if (res_smul !== 9'd0) begin bad++; $display("FAIL l10_res_smul got=%0d want=0", res_smul); end
        total++; if (lc != 1 || li != 0) begin bad++; $display("FAIL l10_lfsr_load got=count%0d@%0d want=count1@0", lc, li); end
        total++; if (ec != 1026) begin bad++; $display("FAIL l10_sn_en_cycles got=%0d want=1026", ec); end
        consume();
    endtask

    task automatic test_clamp();
        int lat, lc, li, ec;
        mode_mul = 3; mode_add = 0; mode_smul = 1;
        run_epoch(9'h100, 9'h0FF, 5'd3, 600, lat, lc, li, ec);
        total++; if (lat != 514) begin bad++; $display("FAIL clamp_lo_latency got=%0d want=514", lat); end
        total++; if (res_mul !== 9'd128) begin bad++; $display("FAIL clamp_lo_res_mul got=%0d want=128", res_mul); end
        total++; if (res_add !== 9'd0 || res_smul !== 9'd511) begin bad++; $display("FAIL clamp_lo_add_smul got=%0d/%0d want=0/511", res_add, res_smul); end
        consume();
        // L=20 clamps to 17: still running well past where L=16 would finish.
        run_epoch(9'h003, 9'h004, 5'd20, 65540, lat, lc, li, ec);
        total++; if (res_valid !== 1'b0 || sn_en !== 1'b1) begin bad++; $display("FAIL clamp_hi_running got=valid%b en%b want=valid0 en1", res_valid, sn_en); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (op_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL clamp_hi_abort got=%b%b want=10", op_ready, busy); end
    endtask

    task automatic test_abort();
        int lat, lc, li, ec, seen;
        mode_mul = 0; mode_add = 1; mode_smul = 2;
        run_epoch(9'h0C3, 9'h03C, 5'd9, WARMUP + 100, lat, lc, li, ec);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (op_ready !== 1'b1 || busy !== 1'b0 || sn_en !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL abort_idle got=rdy%b busy%b en%b vld%b want=rdy1 busy0 en0 vld0", op_ready, busy, sn_en, res_valid);
        end
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_no_result got=%0d want=0", seen); end
        run_epoch(9'h1AA, 9'h055, 5'd9, 600, lat, lc, li, ec);
        total++; if (lat != 514) begin bad++; $display("FAIL abort_next_latency got=%0d want=514", lat); end
        total++; if (res_mul !== 9'd0 || res_add !== 9'd511 || res_smul !== 9'd256) begin
            bad++; $display("FAIL abort_next_results got=%0d/%0d/%0d want=0/511/256", res_mul, res_add, res_smul);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat, lc, li, ec;
        mode_mul = 3; mode_add = 2; mode_smul = 0;
        run_epoch(9'h1FF, 9'h001, 5'd9, 600, lat, lc, li, ec);
        total++; if (lat != 514) begin bad++; $display("FAIL b2b_latency got=%0d want=514", lat); end
        op_a = 9'h055; op_b = 9'h0AA; op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (res_valid !== 1'b1 || res_mul !== 9'd128 || res_add !== 9'd256 || res_smul !== 9'd0
                || op_a_q !== 9'h1FF || op_b_q !== 9'h001 || op_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_hold cyc=%0d got=vld%b %0d/%0d/%0d a%h b%h rdy%b want=vld1 128/256/0 a1ff b001 rdy0",
                         i, res_valid, res_mul, res_add, res_smul, op_a_q, op_b_q, op_ready);
            end
            @(posedge clk); #1;
        end
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL b2b_hs_ready got=%b want=0", op_ready); end
        consume();
        total++; if (op_ready !== 1'b1 || res_valid !== 1'b0 || op_a_q !== 9'h1FF) begin
            bad++; $display("FAIL b2b_bubble got=rdy%b vld%b a%h want=rdy1 vld0 a1ff", op_ready, res_valid, op_a_q);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        total++; if (op_a_q !== 9'h055 || op_b_q !== 9'h0AA) begin bad++; $display("FAIL b2b_accept_opq got=%h/%h want=055/0aa", op_a_q, op_b_q); end
        total++; if (lfsr_load !== 1'b1 || busy !== 1'b1 || op_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_accept_flags got=load%b busy%b rdy%b want=load1 busy1 rdy0", lfsr_load, busy, op_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, lc, li, ec;
        repeat (50) @(posedge clk);
        #1;
        total++; if (sn_en !== 1'b1) begin bad++; $display("FAIL rmr_running got=%b want=1", sn_en); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (op_ready !== 1'b1 || busy !== 1'b0 || sn_en !== 1'b0 || res_valid !== 1'b0 || lfsr_load !== 1'b0) begin
            bad++; $display("FAIL rmr_flags got=rdy%b busy%b en%b vld%b load%b want=rdy1 busy0 en0 vld0 load0",
                            op_ready, busy, sn_en, res_valid, lfsr_load);
        end
        total++; if ({op_a_q, op_b_q, res_mul, res_add, res_smul} !== '0) begin
            bad++; $display("FAIL rmr_values got=a%h b%h %0d/%0d/%0d want=all zero", op_a_q, op_b_q, res_mul, res_add, res_smul);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        mode_mul = 1; mode_add = 1; mode_smul = 3;
        run_epoch(9'h001, 9'h002, 5'd9, 600, lat, lc, li, ec);
        total++; if (lat != 514 || res_mul !== 9'd511 || res_add !== 9'd511 || res_smul !== 9'd128) begin
            bad++; $display("FAIL rmr_next got=lat%0d %0d/%0d/%0d want=lat514 511/511/128", lat, res_mul, res_add, res_smul);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_l9_basic();
        test_l10();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stochastic_epoch_controller.md
# stochastic_epoch_controller

Sequencing controller for the stochastic add/multiply datapath. It accepts an operand pair over a valid/ready handshake and holds the operands steady for the SN generators. It seeds the LFSR, runs one bitstream epoch of programmable length 2^L cycles, and counts the ones on the multiplier, adder and self-multiplier output bits. At epoch end it returns three scaled 9-bit results over a valid/ready handshake, replacing the free-running global clk_counter epoch scheme.

## Interface
Parameters:
- OPW, 9, operand and result width
- WARMUP, 2, cycles of bitstream run before counting starts (fills self-multiplier delay flop); legal range 1..15

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- cfg_log2_len  in  5  epoch length exponent L; sampled only at operand acceptance
- op_valid  in  1  operand pair offered
- op_ready  out  1  controller can accept operands
- op_a, op_b  in  OPW  operand values
- op_a_q, op_b_q  out  OPW  held operands driven to SN generators
- lfsr_load  out  1  one-cycle pulse; datapath reloads LFSR seed
- sn_en  out  1  datapath advancing (LFSR step enable)
- sn_mul, sn_add, sn_smul  in  1  stochastic output bits from datapath
- abort  in  1  synchronous abandon of current epoch
- res_valid  out  1  results available
- res_ready  in  1  consumer takes results
- res_mul, res_add, res_smul  out  OPW  scaled results
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WARM, RUN, DONE.
- IDLE:
  - op_ready=1.
  - On op_valid&op_ready: latch op_a/op_b into op_a_q/op_b_q.
  - Latch clamped L: L<9 -> 9, L>17 -> 17.
  - Clear the three 18-bit ones counters and the cycle counter; go to WARM.
- WARM:
  - Lasts exactly WARMUP cycles; sn_en=1; lfsr_load=1 in the first WARM cycle only.
  - sn_* are ignored (not counted); then go to RUN.
- RUN:
  - Lasts exactly 2^L cycles; sn_en=1.
  - Each cycle, each counter increments when its sn_* bit is 1.
  - After the 2^L-th sample, go to DONE.
- DONE:
  - sn_en=0; res_valid=1; results = min(count >> (L-9), 511) per channel.
  - A full-ones count of 2^L saturates to 511.
  - Hold all results stable until res_valid&res_ready, then go to IDLE.
- abort=1 in WARM or RUN:
  - Next state IDLE; no result produced; counters untouched until next acceptance.
  - In IDLE or DONE, abort is ignored (DONE must still complete its handshake).
- op_a_q/op_b_q change only at acceptance; stable for the whole epoch and the DONE state.
- cfg_log2_len changes mid-epoch have no effect.

## Timing
Reset values (asynchronous on rst_n=0):
- state=IDLE, op_ready=1, op_a_q=op_b_q=0, all counters 0.
- lfsr_load=0, sn_en=0, res_valid=0, results 0, busy=0.

Cycle timing:
- Acceptance edge E0. WARM covers the cycles after E0 .. E_WARMUP; lfsr_load is high in the cycle after E0.
- RUN samples sn_* at edges E_(WARMUP+1) .. E_(WARMUP+2^L).
- res_valid is high from E_(WARMUP+2^L); latency WARMUP+2^L cycles (514 for L=9, WARMUP=2).
- Results are registered outputs, valid in the same cycle as res_valid.
- op_ready is 0 in DONE, including the cycle of the res handshake. The earliest next acceptance is the cycle after the res handshake, so there is 1 bubble.
- Reset mid-epoch: immediate return to IDLE with reset values; no partial result.
- Counter width is 18 bits, so 2^17 ones does not wrap.

## Test plan
- Reset: assert rst_n=0 mid-RUN -> next cycle op_ready=1, busy=0, sn_en=0, res_valid=0, all outputs 0.
- L=9, sn_mul tied 1, sn_add tied 0, sn_smul alternating 1/0 -> res_valid exactly 514 cycles after acceptance; res_mul=511 (saturated), res_add=0, res_smul=256.
- L=10, sn_mul alternating -> count 512, res_mul=256. Also check lfsr_load is a single pulse in the first WARM cycle and sn_en stays high for exactly 2+1024 cycles.
- cfg_log2_len=3 -> clamped to 9, latency 514. cfg_log2_len=20 -> clamped to 17, latency 131074. Change cfg mid-epoch -> no effect.
- abort pulsed in cycle 100 of RUN -> IDLE next cycle, res_valid never asserts. Next operand pair is accepted immediately and produces correct results.
- res_ready held low 5 cycles in DONE with op_valid=1 -> results and op_a_q stable, op_ready=0 throughout. After the handshake, the operands are accepted the following cycle.
